// File: rtl/hamming_pkg.sv
// Shared types, field offsets and parity helpers for the product-code decoder.
package hamming_pkg;

    localparam int unsigned DATA_W   = 64;
    localparam int unsigned CW_W     = 111;
    localparam int unsigned DATA_LSB = 47;
    localparam int unsigned H_LSB    = 35;
    localparam int unsigned V_LSB    = 23;
    localparam int unsigned D1_LSB   = 11;
    localparam int unsigned D2_LSB   = 0;

    // Hamming positions (1-based) that carry field data bits 0..7
    localparam int unsigned DATA_POS [8] = '{3, 5, 6, 7, 9, 10, 11, 12};

    typedef enum logic [1:0] {
        ST_OK        = 2'd0,
        ST_CORR_DATA = 2'd1,
        ST_CORR_PAR  = 2'd2,
        ST_UNCORR    = 2'd3
    } status_e;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [7:0]        h_rx;
        logic [7:0]        h_calc;
        logic [7:0]        v_rx;
        logic [7:0]        v_calc;
        logic [14:0]       d_rx;
        logic [14:0]       d_calc;
        logic              syn_nz;
        logic              field_bad;
    } s2_t;

    function automatic logic [7:0] row_par(input logic [DATA_W-1:0] d);
        logic [7:0] p;
        p = '0;
        for (int unsigned r = 0; r < 8; r++) begin
            p[r] = ^d[8*r +: 8];
        end
        return p;
    endfunction

    function automatic logic [7:0] col_par(input logic [DATA_W-1:0] d);
        logic [7:0] p;
        p = '0;
        for (int unsigned r = 0; r < 8; r++) begin
            for (int unsigned c = 0; c < 8; c++) begin
                p[c] = p[c] ^ d[8*r + c];
            end
        end
        return p;
    endfunction

    // d[k] covers the anti-diagonal r+c = 14-k
    function automatic logic [14:0] diag_par(input logic [DATA_W-1:0] d);
        logic [14:0] p;
        p = '0;
        for (int unsigned r = 0; r < 8; r++) begin
            for (int unsigned c = 0; c < 8; c++) begin
                p[14 - (r + c)] = p[14 - (r + c)] ^ d[8*r + c];
            end
        end
        return p;
    endfunction

endpackage

// File: rtl/hamming_sec_dec.sv
// Combinational single-error-correcting Hamming decoder for one parity field.
module hamming_sec_dec
    import hamming_pkg::*;
#(
    parameter int unsigned N = 12,
    parameter int unsigned K = 8
) (
    input  logic [N-1:0] cw,
    output logic [K-1:0] data,
    output logic         syn_nz,
    output logic         field_bad
);

    logic [3:0] syn;

    always_comb begin
        syn = '0;
        for (int unsigned i = 1; i <= N; i++) begin
            if (cw[i-1]) syn = syn ^ 4'(i);
        end
        syn_nz    = |syn;
        field_bad = syn > 4'(N);
    end

    // A syndrome beyond the code length matches no position, so nothing flips
    always_comb begin
        data = '0;
        for (int unsigned j = 0; j < K; j++) begin
            data[j] = cw[DATA_POS[j]-1] ^ (syn == 4'(DATA_POS[j]));
        end
    end

endmodule

// File: rtl/hamming_product_decoder.sv
// Three-stage elastic decoder for the 111-bit row/column/anti-diagonal product code.
module hamming_product_decoder
    import hamming_pkg::*;
#(
    parameter int unsigned CNT_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CW_W-1:0]   in_cw,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        out_status,
    input  logic              cnt_clr,
    output logic [CNT_W-1:0]  cnt_corr,
    output logic [CNT_W-1:0]  cnt_uncorr
);

    logic            v1, v2;
    logic [CW_W-1:0] cw1;
    s2_t             s2_d, s2_q;
    logic            s2_en, s3_en;

    assign s3_en    = ~out_valid | out_ready;
    assign s2_en    = ~v2 | s3_en;
    assign in_ready = ~v1 | s2_en;

    // Stage 2: field SEC decode and parity recomputation
    logic [7:0] h_fd, v_fd, d1_fd;
    logic [6:0] d2_fd;
    logic [3:0] nz, bad;

    hamming_sec_dec #(.N(12), .K(8)) u_dec_h (
        .cw(cw1[H_LSB +: 12]), .data(h_fd), .syn_nz(nz[0]), .field_bad(bad[0]));
    hamming_sec_dec #(.N(12), .K(8)) u_dec_v (
        .cw(cw1[V_LSB +: 12]), .data(v_fd), .syn_nz(nz[1]), .field_bad(bad[1]));
    hamming_sec_dec #(.N(12), .K(8)) u_dec_d1 (
        .cw(cw1[D1_LSB +: 12]), .data(d1_fd), .syn_nz(nz[2]), .field_bad(bad[2]));
    hamming_sec_dec #(.N(11), .K(7)) u_dec_d2 (
        .cw(cw1[D2_LSB +: 11]), .data(d2_fd), .syn_nz(nz[3]), .field_bad(bad[3]));

    always_comb begin
        s2_d.data      = cw1[DATA_LSB +: DATA_W];
        s2_d.h_rx      = h_fd;
        s2_d.v_rx      = v_fd;
        s2_d.d_rx      = {d2_fd, d1_fd};
        s2_d.h_calc    = row_par(s2_d.data);
        s2_d.v_calc    = col_par(s2_d.data);
        s2_d.d_calc    = diag_par(s2_d.data);
        s2_d.syn_nz    = |nz;
        s2_d.field_bad = |bad;
    end

    // Stage 3: classify the mismatch pattern and fix a lone data error
    logic [7:0]        mh, mv;
    logic [14:0]       md;
    logic [2:0]        r_idx, c_idx;
    logic [DATA_W-1:0] data_c;
    status_e           status_c;

    always_comb begin
        mh       = s2_q.h_rx ^ s2_q.h_calc;
        mv       = s2_q.v_rx ^ s2_q.v_calc;
        md       = s2_q.d_rx ^ s2_q.d_calc;
        r_idx    = '0;
        c_idx    = '0;
        data_c   = s2_q.data;
        status_c = ST_UNCORR;
        for (int unsigned i = 0; i < 8; i++) begin
            if (mh[i]) r_idx = 3'(i);
            if (mv[i]) c_idx = 3'(i);
        end
        if (s2_q.field_bad) begin
            status_c = ST_UNCORR;
        end else if (mh == '0 && mv == '0 && md == '0) begin
            status_c = s2_q.syn_nz ? ST_CORR_PAR : ST_OK;
        end else if ($onehot(mh) && $onehot(mv) &&
                     md == (15'(1) << (4'(14) - (4'(r_idx) + 4'(c_idx))))) begin
            data_c[{r_idx, c_idx}] = ~s2_q.data[{r_idx, c_idx}];
            status_c               = ST_CORR_DATA;
        end
    end

    // Pipeline registers; each stage loads whenever it is empty or draining
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1         <= 1'b0;
            cw1        <= '0;
            v2         <= 1'b0;
            s2_q       <= '0;
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_status <= '0;
        end else begin
            if (in_ready) begin
                v1  <= in_valid;
                cw1 <= in_cw;
            end
            if (s2_en) begin
                v2   <= v1;
                s2_q <= s2_d;
            end
            if (s3_en) begin
                out_valid  <= v2;
                out_data   <= data_c;
                out_status <= status_c;
            end
        end
    end

    // Saturating event counters, clear wins over a same-cycle increment
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_corr   <= '0;
            cnt_uncorr <= '0;
        end else if (cnt_clr) begin
            cnt_corr   <= '0;
            cnt_uncorr <= '0;
        end else if (out_valid && out_ready) begin
            if ((out_status == 2'(ST_CORR_DATA) || out_status == 2'(ST_CORR_PAR)) &&
                cnt_corr != '1) begin
                cnt_corr <= cnt_corr + CNT_W'(1);
            end
            if (out_status == 2'(ST_UNCORR) && cnt_uncorr != '1) begin
                cnt_uncorr <= cnt_uncorr + CNT_W'(1);
            end
        end
    end

endmodule
